core_mem_sequencer: RTL and testbench



---
 rtl/core_mem_sequencer_pkg.sv | 25 ++
 rtl/mem_ift.sv | 34 +++
 rtl/core_mem_sequencer_watchdog.sv | 23 ++
 rtl/core_mem_sequencer.sv | 130 +++++++++++++
 tb/tb_core_mem_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/core_mem_sequencer_pkg.sv
// Shared types for the multi-cycle memory sequencer: state encoding, widths,
// and state-class helpers.
package core_mem_sequencer_pkg;

  localparam int MEM_SEQ_TIMEOUT_DFLT = 256;
  localparam int ADDR_W_DFLT          = 64;
  localparam int DATA_W_DFLT          = 64;

  typedef logic [ADDR_W_DFLT-1:0]   addr_t;
  typedef logic [DATA_W_DFLT-1:0]   data_t;
  typedef logic [DATA_W_DFLT/8-1:0] mask_t;

  typedef enum logic [3:0] {
    IDLE, F_REQ, F_WAIT, DEC, L_REQ, L_WAIT, S_REQ, S_WAIT, COMMIT, HALT
  } seq_state_t;

  function automatic logic is_req_state(seq_state_t s);
    return (s == F_REQ) || (s == L_REQ) || (s == S_REQ);
  endfunction

  function automatic logic is_wait_state(seq_state_t s);
    return (s == F_WAIT) || (s == L_WAIT) || (s == S_WAIT);
  endfunction

endpackage

// File: rtl/mem_ift.sv
// Unified memory port: independent read and write request/reply channels,
// each a valid/ready handshake.
interface Mem_ift #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                r_request_valid;
  logic                r_request_ready;
  logic [ADDR_W-1:0]   raddr;
  logic                r_reply_valid;
  logic                r_reply_ready;
  logic [DATA_W-1:0]   rdata;
  logic                w_request_valid;
  logic                w_request_ready;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wmask;
  logic                w_reply_valid;
  logic                w_reply_ready;

  modport Master (
    output r_request_valid, raddr, r_reply_ready,
    output w_request_valid, waddr, wdata, wmask, w_reply_ready,
    input  r_request_ready, r_reply_valid, rdata,
    input  w_request_ready, w_reply_valid
  );

  modport Slave (
    input  r_request_valid, raddr, r_reply_ready,
    input  w_request_valid, waddr, wdata, wmask, w_reply_ready,
    output r_request_ready, r_reply_valid, rdata,
    output w_request_ready, w_reply_valid
  );
endinterface

// File: rtl/core_mem_sequencer_watchdog.sv
// Wait-state counter for the sequencer; flags expiry on the cycle that would
// complete LIMIT consecutive stalled cycles in one state.
module mem_seq_watchdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic expire
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (clear)   cnt <= '0;
    else if (waiting) cnt <= cnt + CW'(1);
  end

  assign expire = waiting && (cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/core_mem_sequencer.sv
// Serialises fetch / optional load or store / commit over one memory port and
// stalls the core outside COMMIT. Optional wait timeout: MEM_SEQ_TIMEOUT_EN.
module core_mem_sequencer
  import core_mem_sequencer_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DFLT,
  parameter int DATA_W         = DATA_W_DFLT,
  parameter int TIMEOUT_CYCLES = MEM_SEQ_TIMEOUT_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   pc,
  input  logic                re_mem,
  input  logic                we_mem,
  input  logic [ADDR_W-1:0]   alu_res,
  input  logic [DATA_W-1:0]   data_package,
  input  logic [DATA_W/8-1:0] mask_package,
  Mem_ift.Master              mem_ift,
  output logic [DATA_W-1:0]   inst_word,
  output logic [DATA_W-1:0]   load_word,
  output logic                stall,
  output logic                bus_err
);

  seq_state_t          state, state_n;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W/8-1:0] mask_q;

`ifdef MEM_SEQ_TIMEOUT_EN
  logic waiting, expire;

  // The awaited handshake input for the current state is low.
  always_comb begin
    waiting = 1'b0;
    case (state)
      F_REQ, L_REQ:   waiting = !mem_ift.r_request_ready;
      F_WAIT, L_WAIT: waiting = !mem_ift.r_reply_valid;
      S_REQ:          waiting = !mem_ift.w_request_ready;
      S_WAIT:         waiting = !mem_ift.w_reply_valid;
      default:        waiting = 1'b0;
    endcase
  end

  mem_seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_n != state),
    .waiting (waiting),
    .expire  (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         bus_err <= 1'b0;
    else if (expire) bus_err <= 1'b1;
  end
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      inst_word <= '0;
      load_word <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
    end else begin
      state <= state_n;
      if (state == F_WAIT && mem_ift.r_reply_valid) inst_word <= mem_ift.rdata;
      if (state == L_WAIT && mem_ift.r_reply_valid) load_word <= mem_ift.rdata;
      if (state == DEC) begin
        addr_q <= alu_res;
        data_q <= data_package;
        mask_q <= mask_package;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = F_REQ;
      F_REQ:  if (mem_ift.r_request_ready) state_n = F_WAIT;
      F_WAIT: if (mem_ift.r_reply_valid)   state_n = DEC;
      // A simultaneous load and store decode resolves to the load.
      DEC:    state_n = re_mem ? L_REQ : (we_mem ? S_REQ : COMMIT);
      L_REQ:  if (mem_ift.r_request_ready) state_n = L_WAIT;
      L_WAIT: if (mem_ift.r_reply_valid)   state_n = COMMIT;
      S_REQ:  if (mem_ift.w_request_ready) state_n = S_WAIT;
      S_WAIT: if (mem_ift.w_reply_valid)   state_n = COMMIT;
      COMMIT: state_n = F_REQ;
      HALT:   state_n = HALT;
      default: state_n = IDLE;
    endcase
`ifdef MEM_SEQ_TIMEOUT_EN
    if (expire) state_n = HALT;
`endif
  end

  // Outputs are pure functions of state so reset clears them in the same cycle.
  always_comb begin
    stall                   = 1'b1;
    mem_ift.r_request_valid = 1'b0;
    mem_ift.raddr           = '0;
    mem_ift.r_reply_ready   = 1'b0;
    mem_ift.w_request_valid = 1'b0;
    mem_ift.waddr           = '0;
    mem_ift.wdata           = '0;
    mem_ift.wmask           = '0;
    mem_ift.w_reply_ready   = 1'b0;
    if (is_req_state(state) && state != S_REQ) begin
      mem_ift.r_request_valid = 1'b1;
      mem_ift.raddr           = (state == F_REQ) ? pc : addr_q;
    end
    if (state == S_REQ) begin
      mem_ift.w_request_valid = 1'b1;
      mem_ift.waddr           = addr_q;
      mem_ift.wdata           = data_q;
      mem_ift.wmask           = mask_q;
    end
    if (is_wait_state(state)) begin
      mem_ift.r_reply_ready = (state != S_WAIT);
      mem_ift.w_reply_ready = (state == S_WAIT);
    end
    if (state == COMMIT) stall = 1'b0;
  end

endmodule

// File: tb/tb_core_mem_sequencer.sv
// Directed bench for core_mem_sequencer with a small one-in-flight memory responder.
module tb_core_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc, alu_res, data_package;
  logic [7:0]  mask_package;
  logic        re_mem, we_mem;
  logic [63:0] inst_word, load_word;
  logic        stall, bus_err;

  Mem_ift #(.ADDR_W(64), .DATA_W(64)) mem ();

  core_mem_sequencer #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .re_mem       (re_mem),
    .we_mem       (we_mem),
    .alu_res      (alu_res),
    .data_package (data_package),
    .mask_package (mask_package),
    .mem_ift      (mem),
    .inst_word    (inst_word),
    .load_word    (load_word),
    .stall        (stall),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  // Memory responder: optional request back-pressure, reply one cycle after acceptance.
  int          rd_delay, wr_delay, rw_cnt, ww_cnt;
  logic        no_reply;
  int          rd_cnt = 0, wr_cnt = 0;
  logic [63:0] last_raddr = '0, last_waddr = '0, last_wdata = '0;
  logic [7:0]  last_wmask = '0;

  function automatic logic [63:0] rd_data(input logic [63:0] a);
    case (a)
      64'h0:    return 64'h00000000_00B50533;
      64'h1008: return 64'hDEADBEEF_CAFEF00D;
      default:  return a ^ 64'h5A5A_0000_0000_A5A5;
    endcase
  endfunction

  assign mem.r_request_ready = (rw_cnt >= rd_delay);
  assign mem.w_request_ready = (ww_cnt >= wr_delay);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem.r_reply_valid <= 1'b0;
      mem.rdata         <= '0;
      mem.w_reply_valid <= 1'b0;
      rw_cnt            <= 0;
      ww_cnt            <= 0;
    end else begin
      if (mem.r_reply_valid && mem.r_reply_ready) mem.r_reply_valid <= 1'b0;
      if (mem.w_reply_valid && mem.w_reply_ready) mem.w_reply_valid <= 1'b0;
      if (mem.r_request_valid && mem.r_request_ready) begin
        if (!no_reply) begin
          mem.r_reply_valid <= 1'b1;
          mem.rdata         <= rd_data(mem.raddr);
        end
        rd_cnt     <= rd_cnt + 1;
        last_raddr <= mem.raddr;
        rw_cnt     <= 0;
      end else if (mem.r_request_valid) rw_cnt <= rw_cnt + 1;
      if (mem.w_request_valid && mem.w_request_ready) begin
        mem.w_reply_valid <= 1'b1;
        wr_cnt     <= wr_cnt + 1;
        last_waddr <= mem.waddr;
        last_wdata <= mem.wdata;
        last_wmask <= mem.wmask;
        ww_cnt     <= 0;
      end else if (mem.w_request_valid) ww_cnt <= ww_cnt + 1;
    end
  end

  int passed = 0, total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at the cycle-1 (F_REQ) negedge; returns at the COMMIT negedge.
  int          wr_seen;
  logic        hold_bad;
  logic [63:0] exp_waddr, exp_wdata;
  logic [7:0]  exp_wmask;

  task automatic run_instr(output int n);
    n = 0; wr_seen = 0; hold_bad = 1'b0;
    forever begin
      n++;
      if (mem.w_request_valid) begin
        wr_seen++;
        if (mem.waddr !== exp_waddr || mem.wdata !== exp_wdata || mem.wmask !== exp_wmask)
          hold_bad = 1'b1;
      end
      if (stall === 1'b0 || n >= 60) break;
      @(negedge clk);
    end
  endtask

  int n, rd0, wr0;

  initial begin
    rst = 1'b1; pc = '0; alu_res = '0; data_package = '0; mask_package = '0;
    re_mem = 1'b0; we_mem = 1'b0; no_reply = 1'b0; rd_delay = 0; wr_delay = 0;
    exp_waddr = '0; exp_wdata = '0; exp_wmask = '0;
    repeat (2) @(negedge clk);
    check("rst_stall",     64'(stall), 64'd1);
    check("rst_inst_word", inst_word, 64'd0);
    check("rst_load_word", load_word, 64'd0);
    check("rst_bus_err",   64'(bus_err), 64'd0);
    check("rst_rvalid",    64'(mem.r_request_valid), 64'd0);
    check("rst_wvalid",    64'(mem.w_request_valid), 64'd0);
    rst = 1'b0;
    #1 check("idle_rvalid", 64'(mem.r_request_valid), 64'd0);

    // 1: non-memory instruction at pc=0
    @(negedge clk);
    check("t1_rvalid", 64'(mem.r_request_valid), 64'd1);
    check("t1_raddr",  mem.raddr, 64'h0);
    run_instr(n);
    check("t1_cycles",    64'(n), 64'd4);
    check("t1_inst_word", inst_word, 64'h00000000_00B50533);
    check("t1_no_write",  64'(wr_seen), 64'd0);

    // 2: load from 0x1008
    pc = 64'h4; re_mem = 1'b1; alu_res = 64'h1008;
    @(negedge clk);
    rd0 = rd_cnt;
    run_instr(n);
    check("t2_cycles",    64'(n), 64'd6);
    check("t2_raddr",     last_raddr, 64'h1008);
    check("t2_load_word", load_word, 64'hDEADBEEF_CAFEF00D);
    check("t2_reads",     64'(rd_cnt - rd0), 64'd2);
    check("t2_inst_word", inst_word, rd_data(64'h4));

    // 3: byte store with three cycles of write back-pressure
    pc = 64'h8; re_mem = 1'b0; we_mem = 1'b1; alu_res = 64'h2003;
    data_package = 64'h00000000_AB000000; mask_package = 8'h08; wr_delay = 3;
    exp_waddr = 64'h2003; exp_wdata = 64'h00000000_AB000000; exp_wmask = 8'h08;
    @(negedge clk);
    wr0 = wr_cnt;
    run_instr(n);
    check("t3_cycles",     64'(n), 64'd9);
    check("t3_held",       64'(hold_bad), 64'd0);
    check("t3_wvalid_cyc", 64'(wr_seen), 64'd4);
    check("t3_writes",     64'(wr_cnt - wr0), 64'd1);
    check("t3_waddr",      last_waddr, 64'h2003);
    check("t3_wdata",      last_wdata, 64'h00000000_AB000000);
    check("t3_wmask",      64'(last_wmask), 64'h08);
    check("t3_load_hold",  load_word, 64'hDEADBEEF_CAFEF00D);

    // 4: reset during L_WAIT
    pc = 64'hC; re_mem = 1'b1; we_mem = 1'b0; alu_res = 64'h1008; wr_delay = 0;
    @(negedge clk);
    repeat (4) @(negedge clk);
    check("t4_in_lwait", 64'(mem.r_reply_ready), 64'd1);
    rst = 1'b1;
    #1;
    check("t4_stall",      64'(stall), 64'd1);
    check("t4_rvalid",     64'(mem.r_request_valid), 64'd0);
    check("t4_wvalid",     64'(mem.w_request_valid), 64'd0);
    check("t4_rready",     64'(mem.r_reply_ready), 64'd0);
    check("t4_load_clear", load_word, 64'd0);
    pc = 64'h40;
    @(negedge clk);
    rst = 1'b0;
    #1 check("t4_idle", 64'(mem.r_request_valid), 64'd0);
    @(negedge clk);
    check("t4_fetch_valid", 64'(mem.r_request_valid), 64'd1);
    check("t4_fetch_raddr", mem.raddr, 64'h40);

    // 5: load and store both decoded; the load wins
    re_mem = 1'b1; we_mem = 1'b1; alu_res = 64'h1008;
    wr0 = wr_cnt;
    run_instr(n);
    check("t5_cycles",    64'(n), 64'd6);
    check("t5_no_wvalid", 64'(wr_seen), 64'd0);
    check("t5_no_write",  64'(wr_cnt - wr0), 64'd0);
    check("t5_raddr",     last_raddr, 64'h1008);
    check("t5_load_word", load_word, 64'hDEADBEEF_CAFEF00D);

`ifdef MEM_SEQ_TIMEOUT_EN
    // 6: fetch reply never arrives; 16 wait cycles in F_WAIT then HALT
    re_mem = 1'b0; we_mem = 1'b0; no_reply = 1'b1;
    @(negedge clk);
    repeat (16) @(negedge clk);
    check("t6_err_early", 64'(bus_err), 64'd0);
    check("t6_waiting",   64'(mem.r_reply_ready), 64'd1);
    @(negedge clk);
    check("t6_bus_err", 64'(bus_err), 64'd1);
    check("t6_rready",  64'(mem.r_reply_ready), 64'd0);
    repeat (5) @(negedge clk);
    check("t6_stall",  64'(stall), 64'd1);
    check("t6_sticky", 64'(bus_err), 64'd1);
    check("t6_rvalid", 64'(mem.r_request_valid), 64'd0);
    rst = 1'b1;
    #1 check("t6_rst_clear", 64'(bus_err), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
